// File: rtl/wb_regfile.sv
// Write-back register file for the R (integer), F (float) and M (matrix) groups.
// It accepts one write-back per handshake from ME and serves NRD combinational
// read ports to EX. Matrix write-backs are staged, then committed one row per cycle.
// A per-register busy scoreboard, together with a same-cycle R/F bypass, lets EX
// detect and resolve hazards.
module wb_regfile #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int MDIM = 4,
    parameter int NRD  = 3,
    localparam int IDXW = $clog2(NREG),
    localparam int MW   = MDIM * MDIM * XLEN,
    localparam int RW   = MDIM * XLEN,
    localparam int ROWW = $clog2(MDIM)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_valid,
    output logic                  wb_ready,
    input  logic [1:0]            wb_group,
    input  logic [IDXW-1:0]       wb_index,
    input  logic [XLEN-1:0]       wb_data,
    input  logic [MW-1:0]         wb_mdata,
    input  logic                  iss_valid,
    input  logic [1:0]            iss_group,
    input  logic [IDXW-1:0]       iss_index,
    input  logic [NRD*2-1:0]      rs_group,
    input  logic [NRD*IDXW-1:0]   rs_index,
    output logic [NRD*XLEN-1:0]   rs_rdata,
    output logic [NRD*MW-1:0]     rs_mdata,
    output logic [NRD-1:0]        rs_busy
);

    typedef enum logic {
        IDLE = 1'b0,
        MROW = 1'b1
    } state_t;

    localparam logic [1:0] G_R = 2'b00;
    localparam logic [1:0] G_F = 2'b01;
    localparam logic [1:0] G_M = 2'b10;

    state_t            state;
    logic [ROWW-1:0]   row;
    logic [IDXW-1:0]   m_idx;
    logic [MW-1:0]     stage;

    logic [XLEN-1:0]   r_mem [NREG];
    logic [XLEN-1:0]   f_mem [NREG];
    logic [MW-1:0]     m_mem [NREG];
    logic [NREG-1:0]   r_busy, f_busy, m_busy;

    logic              accept;
    logic              m_last;

    // Only the state decides whether the file is ready. It never looks at wb_valid.
    assign wb_ready = (state == IDLE);
    assign accept   = wb_valid & wb_ready;
    assign m_last   = (state == MROW) && (row == ROWW'(MDIM - 1));

    // Matrix staging FSM: latch the whole matrix on acceptance, then walk the rows.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            row   <= '0;
            m_idx <= '0;
            stage <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && wb_group == G_M) begin
                        stage <= wb_mdata;
                        m_idx <= wb_index;
                        row   <= '0;
                        state <= MROW;
                    end
                end
                MROW: begin
                    if (m_last) begin
                        row   <= '0;
                        state <= IDLE;
                    end else begin
                        row <= row + ROWW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Register arrays. R0 writes are dropped, and M rows commit from the staging buffer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
                f_mem[i] <= '0;
                m_mem[i] <= '0;
            end
        end else begin
            if (accept && wb_group == G_R && wb_index != '0)
                r_mem[wb_index] <= wb_data;
            if (accept && wb_group == G_F)
                f_mem[wb_index] <= wb_data;
            if (state == MROW)
                m_mem[m_idx][int'(row)*RW +: RW] <= stage[int'(row)*RW +: RW];
        end
    end

    // Scoreboard. The set comes after the clear, so a newer issue to the same register wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy <= '0;
            f_busy <= '0;
            m_busy <= '0;
        end else begin
            if (accept && wb_group == G_R)
                r_busy[wb_index] <= 1'b0;
            if (accept && wb_group == G_F)
                f_busy[wb_index] <= 1'b0;
            if (m_last)
                m_busy[m_idx] <= 1'b0;
            if (iss_valid) begin
                case (iss_group)
                    G_R:     if (iss_index != '0) r_busy[iss_index] <= 1'b1;
                    G_F:     f_busy[iss_index] <= 1'b1;
                    G_M:     m_busy[iss_index] <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [1:0]      grp;
        logic [IDXW-1:0] idx;
        logic            byp;
        logic [XLEN-1:0] rdata;
        logic [MW-1:0]   mdata;
        logic            busy;

        assign grp = rs_group[p*2 +: 2];
        assign idx = rs_index[p*IDXW +: IDXW];
        assign byp = accept && (wb_group == grp) && (wb_index == idx);

        // Per-port read mux. The R/F bypass forwards write-back data in the same cycle.
        // Matrices are never bypassed: they stay busy while their rows are committing.
        always_comb begin
            rdata = '0;
            mdata = '0;
            busy  = 1'b0;
            case (grp)
                G_R: begin
                    if (idx != '0) begin
                        if (byp) begin
                            rdata = wb_data;
                        end else begin
                            rdata = r_mem[idx];
                            busy  = r_busy[idx];
                        end
                    end
                end
                G_F: begin
                    if (byp) begin
                        rdata = wb_data;
                    end else begin
                        rdata = f_mem[idx];
                        busy  = f_busy[idx];
                    end
                end
                G_M: begin
                    mdata = m_mem[idx];
                    busy  = m_busy[idx] | ((state == MROW) && (m_idx == idx));
                end
                default: ;
            endcase
        end

        assign rs_rdata[p*XLEN +: XLEN] = rdata;
        assign rs_mdata[p*MW +: MW]     = mdata;
        assign rs_busy[p]               = busy;
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile. Each expected value is queued when the stimulus
// is driven, then popped and checked against the sampled DUT output.
module tb_wb_regfile;
    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int MDIM = 4;
    localparam int NRD  = 3;
    localparam int IDXW = 5;
    localparam int MW   = MDIM * MDIM * XLEN;

    localparam logic [1:0] G_R = 2'b00;
    localparam logic [1:0] G_F = 2'b01;
    localparam logic [1:0] G_M = 2'b10;

    logic                clk;
    logic                rst;
    logic                wb_valid;
    logic                wb_ready;
    logic [1:0]          wb_group;
    logic [IDXW-1:0]     wb_index;
    logic [XLEN-1:0]     wb_data;
    logic [MW-1:0]       wb_mdata;
    logic                iss_valid;
    logic [1:0]          iss_group;
    logic [IDXW-1:0]     iss_index;
    logic [NRD*2-1:0]    rs_group;
    logic [NRD*IDXW-1:0] rs_index;
    logic [NRD*XLEN-1:0] rs_rdata;
    logic [NRD*MW-1:0]   rs_mdata;
    logic [NRD-1:0]      rs_busy;

    wb_regfile #(.XLEN(XLEN), .NREG(NREG), .MDIM(MDIM), .NRD(NRD)) dut (
        .clk(clk), .rst(rst),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_group(wb_group),
        .wb_index(wb_index), .wb_data(wb_data), .wb_mdata(wb_mdata),
        .iss_valid(iss_valid), .iss_group(iss_group), .iss_index(iss_index),
        .rs_group(rs_group), .rs_index(rs_index),
        .rs_rdata(rs_rdata), .rs_mdata(rs_mdata), .rs_busy(rs_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [MW-1:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   waited;

    task automatic expect_val(input string tag, input logic [MW-1:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic compare(input logic [MW-1:0] obs);
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_err++;
            $error("FAIL scoreboard_empty observed=%0h required=<none>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_err++;
                $error("FAIL %s observed=%0h required=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input int p, input logic [1:0] g, input logic [IDXW-1:0] i);
        rs_group[p*2 +: 2]      = g;
        rs_index[p*IDXW +: IDXW] = i;
    endtask

    function automatic logic [XLEN-1:0] rdat(input int p);
        return rs_rdata[p*XLEN +: XLEN];
    endfunction

    function automatic logic [MW-1:0] mdat(input int p);
        return rs_mdata[p*MW +: MW];
    endfunction

    function automatic logic [MW-1:0] mpat(input int base);
        logic [MW-1:0] v;
        v = '0;
        for (int i = 0; i < MDIM; i++)
            for (int j = 0; j < MDIM; j++)
                v[(i*MDIM+j)*XLEN +: XLEN] = XLEN'(base + i*MDIM + j);
        return v;
    endfunction

    task automatic wb(input logic [1:0] g, input logic [IDXW-1:0] i,
                      input logic [XLEN-1:0] d, input logic [MW-1:0] md);
        wb_valid = 1'b1;
        wb_group = g;
        wb_index = i;
        wb_data  = d;
        wb_mdata = md;
    endtask

    task automatic iss(input logic [1:0] g, input logic [IDXW-1:0] i);
        iss_valid = 1'b1;
        iss_group = g;
        iss_index = i;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        wb_valid = 1'b0; wb_group = 2'b11; wb_index = '0; wb_data = '0; wb_mdata = '0;
        iss_valid = 1'b0; iss_group = 2'b11; iss_index = '0;
        rs_group = '1; rs_index = '0;
        repeat (2) tick();
        rst = 1'b1;
        #1;

        // Reset state
        rd(0, G_M, 1);
        #1;
        expect_val("reset_ready", MW'(1'b1));   compare(MW'(wb_ready));
        expect_val("reset_busy", MW'(0));       compare(MW'(rs_busy));
        expect_val("reset_m1", '0);             compare(mdat(0));

        // Abort an M write with reset at row 2
        wb(G_M, 1, '0, mpat(100));
        tick();
        wb_valid = 1'b0;
        tick();
        tick();
        expect_val("mrow_ready_low", MW'(1'b0)); compare(MW'(wb_ready));
        rst = 1'b0;
        #1;
        expect_val("abort_ready", MW'(1'b1));   compare(MW'(wb_ready));
        expect_val("abort_m1", '0);             compare(mdat(0));
        expect_val("abort_busy", MW'(0));       compare(MW'(rs_busy));
        #1;
        rst = 1'b1;
        tick();
        expect_val("abort_m1_after", '0);       compare(mdat(0));
        expect_val("abort_ready_after", MW'(1'b1)); compare(MW'(wb_ready));

        // R5 write with same-cycle bypass
        rd(0, G_R, 5);
        wb(G_R, 5, 32'hDEADBEEF, '0);
        #1;
        expect_val("r5_bypass", MW'(32'hDEADBEEF)); compare(MW'(rdat(0)));
        expect_val("r5_bypass_busy", MW'(1'b0));    compare(MW'(rs_busy[0]));
        tick();
        wb_valid = 1'b0;
        #1;
        expect_val("r5_array", MW'(32'hDEADBEEF)); compare(MW'(rdat(0)));
        expect_val("r5_busy", MW'(1'b0));          compare(MW'(rs_busy[0]));

        // R0 stays zero and is never marked busy
        rd(1, G_R, 0);
        iss(G_R, 0);
        wb(G_R, 0, 32'h1234, '0);
        #1;
        expect_val("r0_bypass", MW'(0)); compare(MW'(rdat(1)));
        tick();
        iss_valid = 1'b0;
        wb_valid = 1'b0;
        #1;
        expect_val("r0_data", MW'(0));    compare(MW'(rdat(1)));
        expect_val("r0_busy", MW'(1'b0)); compare(MW'(rs_busy[1]));

        // M3 write: ready low for exactly MDIM cycles, busy until the last row
        rd(2, G_M, 3);
        iss(G_M, 3);
        tick();
        iss_valid = 1'b0;
        #1;
        expect_val("m3_issued_busy", MW'(1'b1)); compare(MW'(rs_busy[2]));
        wb(G_M, 3, '0, mpat(0));
        #1;
        expect_val("m3_accept_ready", MW'(1'b1)); compare(MW'(wb_ready));
        tick();
        wb_valid = 1'b0;
        for (int k = 0; k < MDIM; k++) begin
            expect_val($sformatf("m3_ready_low%0d", k), MW'(1'b0)); compare(MW'(wb_ready));
            expect_val($sformatf("m3_busy%0d", k), MW'(1'b1));      compare(MW'(rs_busy[2]));
            tick();
        end
        expect_val("m3_ready_back", MW'(1'b1)); compare(MW'(wb_ready));
        expect_val("m3_busy_clear", MW'(1'b0)); compare(MW'(rs_busy[2]));
        expect_val("m3_data", mpat(0));         compare(mdat(2));

        // F7: a new issue on the write-back edge keeps the register busy
        rd(0, G_F, 7);
        iss(G_F, 7);
        tick();
        iss_valid = 1'b0;
        #1;
        expect_val("f7_busy_set", MW'(1'b1)); compare(MW'(rs_busy[0]));
        wb(G_F, 7, 32'hA5A50007, '0);
        iss(G_F, 7);
        #1;
        expect_val("f7_bypass", MW'(32'hA5A50007)); compare(MW'(rdat(0)));
        expect_val("f7_bypass_busy", MW'(1'b0));    compare(MW'(rs_busy[0]));
        tick();
        wb_valid = 1'b0;
        iss_valid = 1'b0;
        #1;
        expect_val("f7_set_wins", MW'(1'b1));      compare(MW'(rs_busy[0]));
        expect_val("f7_data", MW'(32'hA5A50007));  compare(MW'(rdat(0)));
        wb(G_F, 7, 32'h0000F00D, '0);
        tick();
        wb_valid = 1'b0;
        #1;
        expect_val("f7_busy_cleared", MW'(1'b0)); compare(MW'(rs_busy[0]));
        expect_val("f7_data2", MW'(32'hF00D));    compare(MW'(rdat(0)));

        // R9 write held during MROW is accepted only once IDLE returns
        rd(1, G_R, 9);
        rd(2, G_M, 2);
        iss(G_R, 9);
        tick();
        iss_valid = 1'b0;
        wb(G_M, 2, '0, mpat(50));
        tick();
        wb(G_R, 9, 32'hCAFE0009, '0);
        waited = 0;
        #1;
        while (!wb_ready && waited < 10) begin
            expect_val("r9_not_early", MW'(0)); compare(MW'(rdat(1)));
            tick();
            waited++;
        end
        expect_val("r9_wait_cycles", MW'(MDIM)); compare(MW'(waited));
        tick();
        wb_valid = 1'b0;
        #1;
        expect_val("r9_data", MW'(32'hCAFE0009)); compare(MW'(rdat(1)));
        expect_val("r9_busy", MW'(1'b0));         compare(MW'(rs_busy[1]));
        expect_val("m2_data", mpat(50));          compare(mdat(2));
        expect_val("final_ready", MW'(1'b1));     compare(MW'(wb_ready));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
